// File: rtl/frame_loader.sv
// frame_loader: writes a byte-serial RGB stream into the dual-port image RAM.
module frame_loader #(
  parameter int NUM_IMAGES   = 12,
  parameter int PIXEL_DEPTH  = 8,
  parameter int PANEL_WIDTH  = 64,
  parameter int PANEL_HEIGHT = 32,
  parameter int ADDR_WIDTH   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               img_sel,
  input  logic [7:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [6*PIXEL_DEPTH-1:0] wr_data,
  output logic [1:0]               wr_be,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int CW = $clog2(PANEL_WIDTH);
  localparam int RW = $clog2(PANEL_HEIGHT);
  localparam int PW = 3 * PIXEL_DEPTH;
  localparam logic [CW-1:0] COL_LAST = CW'(PANEL_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PANEL_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_HALF = RW'(PANEL_HEIGHT / 2);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t                 state_q;
  logic [3:0]             img_q;
  logic [RW-1:0]          row_q;
  logic [CW-1:0]          col_q;
  logic [1:0]             byte_q;
  logic [PIXEL_DEPTH-1:0] r_q, g_q;
  logic                   s_ready_q, wr_en_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [2*PW-1:0]        wr_data_q;
  logic [1:0]             wr_be_q;
  logic                   accept, lower, img_ok;
  assign accept  = s_valid && s_ready_q;
  assign lower   = row_q >= ROW_HALF;
  assign img_ok  = {1'b0, img_sel} < 5'(NUM_IMAGES);
  assign s_ready = s_ready_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_be   = wr_be_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      img_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      byte_q    <= '0;
      r_q       <= '0;
      g_q       <= '0;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      case (state_q)
        IDLE: if (start) begin
          if (img_ok) begin
            img_q     <= img_sel;
            row_q     <= '0;
            col_q     <= '0;
            byte_q    <= '0;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
            state_q   <= RECV;
          end else begin
            err_q <= 1'b1;
          end
        end
        RECV: if (accept) begin
          if (byte_q == 2'd0) r_q <= s_data;
          if (byte_q == 2'd1) g_q <= s_data;
          byte_q <= (byte_q == 2'd2) ? 2'd0 : byte_q + 2'd1;
          // B byte goes straight into the write word; upper half holds the top scan rows
          if (byte_q == 2'd2) begin
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= {img_q, 1'b0, row_q[RW-2:0], col_q};
            wr_data_q <= lower ? {{PW{1'b0}}, r_q, g_q, s_data} : {r_q, g_q, s_data, {PW{1'b0}}};
            wr_be_q   <= lower ? 2'b01 : 2'b10;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          if (col_q == COL_LAST) row_q <= row_q + 1'b1;
          if (col_q == COL_LAST && row_q == ROW_LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= RECV;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized scoreboard bench for frame_loader.
module tb_frame_loader;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [3:0]  img_sel = '0;
  logic [7:0]  s_data = '0;
  logic        s_ready, wr_en, busy, done, err;
  logic [14:0] wr_addr;
  logic [47:0] wr_data;
  logic [1:0]  wr_be;
  typedef struct packed {logic [14:0] a; logic [47:0] d; logic [1:0] be;} wr_t;
  wr_t         exp_q[$];
  logic [23:0] pix[2048];
  int          checks = 0, errors = 0, wr_count = 0, cur_img = 0, cur_p = 0;
  logic [14:0] last_addr = '0, first_addr = '0;

  frame_loader dut (
    .clk(clk), .rst(rst), .start(start), .img_sel(img_sel), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_en) begin
      if (wr_count == 0) first_addr = wr_addr;
      wr_count++;
      last_addr = wr_addr;
      chk("s_ready_in_write", s_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0h expected no write", wr_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
        chk("wr_be", wr_be, e.be);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n = 0;
    if (gappy) while ($urandom_range(1, 0) == 1) tick();
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout got 0 expected 1");
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Reference: pixel index -> (row, col); top half rows share words with bottom half rows
  task automatic send_pixel(input logic [23:0] v, input bit gappy);
    int  row = cur_p / 64, col = cur_p % 64;
    wr_t e;
    e.a  = 15'(cur_img * 2048 + (row % 16) * 64 + col);
    e.d  = (row < 16) ? {v, 24'h0} : {24'h0, v};
    e.be = (row < 16) ? 2'b10 : 2'b01;
    exp_q.push_back(e);
    cur_p++;
    send_byte(v[23:16], gappy);
    send_byte(v[15:8], gappy);
    send_byte(v[7:0], gappy);
  endtask

  task automatic do_start(input int sel);
    start   = 1'b1;
    img_sel = 4'(sel);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_at_done"}, busy, 1);
    chk({name, "_writes"}, wr_count, 2048);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_busy_fall"}, busy, 0);
    tick();
  endtask

  task automatic full_image(input string name, input int sel, input bit gappy, input bit mid);
    do_start(sel);
    cur_img  = sel;
    cur_p    = 0;
    wr_count = 0;
    for (int p = 0; p < 2048; p++) begin
      send_pixel(pix[p], gappy);
      if (mid && p == 700) begin
        do_start(5);
        @(negedge clk);
        chk({name, "_mid_start_err"}, err, 0);
        chk({name, "_mid_start_busy"}, busy, 1);
        tick();
      end
    end
    wait_done(name);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 2048; p++) pix[p] = 24'($urandom);
    pix[0]    = 24'h112233;
    pix[1029] = 24'hAABBCC;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_be", wr_be, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();
    do_start(12);
    @(negedge clk);
    chk("bad12_err", err, 1);
    chk("bad12_busy", busy, 0);
    chk("bad12_s_ready", s_ready, 0);
    @(negedge clk);
    chk("bad12_err_pulse", err, 0);
    tick();
    do_start(15);
    @(negedge clk);
    chk("bad15_err", err, 1);
    chk("bad15_busy", busy, 0);
    tick();
    full_image("img2_gappy", 2, 1'b1, 1'b1);
    full_image("img11", 11, 1'b0, 1'b0);
    chk("img11_last_addr", last_addr, 15'h5BFF);
    full_image("img0", 0, 1'b0, 1'b0);
    chk("img0_first_addr", first_addr, 15'h0000);
    do_start(0);
    cur_img = 0;
    cur_p   = 0;
    send_pixel(pix[3], 1'b0);
    send_pixel(pix[4], 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", wr_en, 0);
    repeat (3) @(negedge clk);
    chk("midrst_idle_s_ready", s_ready, 0);
    chk("midrst_no_write", exp_q.size(), 0);
    tick();
    do_start(3);
    cur_img  = 3;
    cur_p    = 0;
    wr_count = 0;
    send_pixel(pix[5], 1'b0);
    repeat (3) @(negedge clk);
    chk("reload_first_addr", first_addr, 15'h1800);
    chk("reload_writes", wr_count, 1);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream stage of the LED matrix display path.
- Receives a byte-serial RGB image stream (row-major, 3 bytes per pixel, R,G,B) and writes it into the dual-port image RAM that the panel scan controller reads.
- Pixel pairs share one 48-bit RAM word: rows 0-15 land in the upper half [47:24], rows 16-31 in the lower half [23:0].
- Address format matches the scan side's read format {image[3:0], 1'b0, row[3:0], col[5:0]}.

Parameters:
- NUM_IMAGES, 12, number of image slots in RAM; valid img_sel is 0..NUM_IMAGES-1.
- PIXEL_DEPTH, 8, bits per colour channel.
- PANEL_WIDTH, 64, columns per image.
- PANEL_HEIGHT, 32, rows per image; must be 2 x scan rows.
- ADDR_WIDTH, 15, RAM write address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins loading the image selected by img_sel.
- img_sel  in  4  target image slot, sampled on an accepted start.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM word address.
- wr_data  out  6*PIXEL_DEPTH  RAM write data.
- wr_be  out  2  half-word enables; [1] = upper [47:24], [0] = lower [23:0].
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse after the last write of an image.
- err  out  1  one-cycle pulse when start has an out-of-range img_sel.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; counters, image register and byte buffer cleared.
- Reset mid-load returns to IDLE next cycle; no partial-pixel write is issued.
- A byte transfers on a cycle with s_valid && s_ready. s_ready is a registered FSM output: 1 only in RECV, independent of s_valid.
- State IDLE:
  - start with img_sel < NUM_IMAGES: latch img, clear row/col/byte counters, go to RECV, busy=1.
  - start with img_sel >= NUM_IMAGES: err=1 for one cycle, stay IDLE.
  - Bytes presented while in IDLE are not accepted.
- State RECV:
  - Accepted bytes are stored by byte_cnt: 0=R, 1=G, 2=B.
  - On accepting the B byte, go to WRITE. byte_cnt wraps to 0.
  - A gap in s_valid holds the state; no timeout.
- State WRITE, exactly one cycle:
  - s_ready=0, wr_en=1.
  - wr_addr = {img, 1'b0, row[3:0], col[5:0]}.
  - row < 16: wr_data = {R,G,B,24'h0}, wr_be = 2'b10.
  - row >= 16: wr_data = {24'h0,R,G,B}, wr_be = 2'b01.
  - Then col increments. When col = PANEL_WIDTH-1, col wraps to 0 and row increments.
  - If this was row 31 col 63, go to DONE; otherwise return to RECV.
- State DONE: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- start received while busy is ignored: no restart, no err.
- Throughput: one pixel per 4 cycles at full s_valid; 2048 writes per image.
- wr_en, wr_addr, wr_data and wr_be are registered; they are valid only when wr_en=1 and are 0 otherwise.
- The scan side reads concurrently. This block does not arbitrate; the RAM is true dual-port with byte-enables on the write port.

Test Plan:
- After reset: all outputs 0. Then start, img_sel=2, stream bytes 0x11,0x22,0x33 → a single wr_en cycle with wr_addr=0x1000, wr_data=0x112233000000, wr_be=2'b10.
- Stream pixels up to row 16 col 5 with value 0xAA,0xBB,0xCC → wr_addr={2,0,4'h0,6'd5}=0x1005, wr_data=0x000000AABBCC, wr_be=2'b01.
- Full 6144-byte image to slot 11 → exactly 2048 wr_en pulses, last wr_addr=0x5BFF, then done for 1 cycle and busy falls; a second full image to slot 0 starts at 0x0000.
- start with img_sel=12 → err pulses 1 cycle, busy stays 0, no writes. start during busy → ignored, addresses continue the sequence.
- Random s_valid gaps (about 50% duty) → write sequence and data are identical to the gap-free run; s_ready=0 in every WRITE cycle.
- rst asserted after 2 bytes of a pixel → no write, IDLE next cycle; a new start then reloads from row 0 col 0.
